// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_ADDR  = 0;

  // Smallest counter width whose maximum value still covers every register.
  function automatic int cnt_width(input int depth);
    int w;
    w = 1;
    while (((1 << w) - 1) < depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register busy bits: reserve sets, release clears, with a running count of busy entries.
module regfile_busy_tracker
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rel_addr,
  input  logic              rel_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              rsv_en,
  output logic [DEPTH-1:0]  busy,
  output logic              accept,
  output logic [CNT_W-1:0]  count
);

  logic             rel_ok;
  logic             rsv_zero;
  logic             rsv_busy;
  logic             rel_busy;
  logic             set_ok;
  logic             inc;
  logic             dec;
  logic [DEPTH-1:0] busy_nxt;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == ADDR_W'(ZERO_ADDR));
  endfunction

  always_comb begin
    rsv_busy = 1'b0;
    rel_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rsv_addr == ADDR_W'(i)) rsv_busy = busy[i];
      if (rel_addr == ADDR_W'(i)) rel_busy = busy[i];
    end
  end

  // A busy target is still clear if the same cycle's writeback releases it.
  assign rel_ok   = rel_en && in_range(rel_addr) && !is_zero(rel_addr);
  assign rsv_zero = is_zero(rsv_addr);
  assign accept   = rsv_en && in_range(rsv_addr) &&
                    (rsv_zero || !rsv_busy || (rel_ok && (rel_addr == rsv_addr)));
  assign set_ok   = accept && !rsv_zero;
  assign inc      = set_ok && !rsv_busy;
  assign dec      = rel_ok && rel_busy && !(set_ok && (rel_addr == rsv_addr));

  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < DEPTH; i++) begin
      if (rel_ok && (rel_addr == ADDR_W'(i))) busy_nxt[i] = 1'b0;
      if (set_ok && (rsv_addr == ADDR_W'(i))) busy_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= '0;
      count <= '0;
    end else begin
      busy  <= busy_nxt;
      count <= count + CNT_W'(inc) - CNT_W'(dec);
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with optional zero entry, write bypass and busy scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int CNT_W    = cnt_width(DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  output logic              ReadBusy1,
  output logic              ReadBusy2,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] ReserveRegister,
  input  logic              Reserve,
  output logic              ReserveAccept,
  output logic [CNT_W-1:0]  BusyCount
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             wr_ok;

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == ADDR_W'(ZERO_ADDR)));
  endfunction

  function automatic logic [WIDTH-1:0] pick_data(input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < DEPTH; i++)
      if (a == ADDR_W'(i)) d = mem[i];
    return d;
  endfunction

  function automatic logic pick_busy(input logic [ADDR_W-1:0] a);
    logic b;
    b = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (a == ADDR_W'(i)) b = busy[i];
    return b;
  endfunction

  assign wr_ok = RegWrite && writable(WriteRegister);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_ok && (WriteRegister == ADDR_W'(i))) mem[i] <= WriteData;
    end
  end

  // Unwritable addresses read as idle zero; bypass makes a landing write visible early.
  always_comb begin
    ReadData1 = '0;
    ReadBusy1 = 1'b0;
    if (writable(ReadRegister1)) begin
      ReadData1 = pick_data(ReadRegister1);
      ReadBusy1 = pick_busy(ReadRegister1);
      if ((BYPASS != 0) && wr_ok && (WriteRegister == ReadRegister1)) begin
        ReadData1 = WriteData;
        ReadBusy1 = 1'b0;
      end
    end
  end

  always_comb begin
    ReadData2 = '0;
    ReadBusy2 = 1'b0;
    if (writable(ReadRegister2)) begin
      ReadData2 = pick_data(ReadRegister2);
      ReadBusy2 = pick_busy(ReadRegister2);
      if ((BYPASS != 0) && wr_ok && (WriteRegister == ReadRegister2)) begin
        ReadData2 = WriteData;
        ReadBusy2 = 1'b0;
      end
    end
  end

  regfile_busy_tracker #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .CNT_W    (CNT_W)
  ) u_busy (
    .clk      (Clk),
    .rst      (Reset),
    .rel_addr (WriteRegister),
    .rel_en   (RegWrite),
    .rsv_addr (ReserveRegister),
    .rsv_en   (Reserve),
    .busy     (busy),
    .accept   (ReserveAccept),
    .count    (BusyCount)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus random traffic against an array-based model.
module tb_regfile_scoreboard;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 5;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rr1 = '0, rr2 = '0, wa = '0, ra = '0;
  logic [W-1:0]  wd = '0;
  logic          we = 1'b0, rsv = 1'b0;

  logic [W-1:0]  rd1, rd2, rd1_nb, rd2_nb;
  logic          rb1, rb2, acc, rb1_nb, rb2_nb, acc_nb;
  logic [CW-1:0] cnt, cnt_nb;

  logic [W-1:0]  m_reg [D];
  bit            m_busy [D];
  int            vec_cnt = 0;
  int            err_cnt = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1), .CNT_W(CW)) dut (
    .Clk(clk), .Reset(rst), .ReadRegister1(rr1), .ReadRegister2(rr2),
    .ReadData1(rd1), .ReadData2(rd2), .ReadBusy1(rb1), .ReadBusy2(rb2),
    .WriteRegister(wa), .WriteData(wd), .RegWrite(we),
    .ReserveRegister(ra), .Reserve(rsv), .ReserveAccept(acc), .BusyCount(cnt));

  regfile_scoreboard #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0), .CNT_W(CW)) dut_nb (
    .Clk(clk), .Reset(rst), .ReadRegister1(rr1), .ReadRegister2(rr2),
    .ReadData1(rd1_nb), .ReadData2(rd2_nb), .ReadBusy1(rb1_nb), .ReadBusy2(rb2_nb),
    .WriteRegister(wa), .WriteData(wd), .RegWrite(we),
    .ReserveRegister(ra), .Reserve(rsv), .ReserveAccept(acc_nb), .BusyCount(cnt_nb));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_writable(input logic [AW-1:0] a);
    return (int'(a) < D) && (a != 0);
  endfunction

  function automatic logic [W-1:0] m_data(input logic [AW-1:0] a, input bit byp);
    if (!m_writable(a)) return '0;
    if (byp && we && wa == a) return wd;
    return m_reg[a[3:0]];
  endfunction

  function automatic bit m_rbusy(input logic [AW-1:0] a, input bit byp);
    if (!m_writable(a)) return 1'b0;
    if (byp && we && wa == a) return 1'b0;
    return m_busy[a[3:0]];
  endfunction

  function automatic bit m_accept();
    if (!rsv || int'(ra) >= D) return 1'b0;
    if (ra == 0) return 1'b1;
    return !m_busy[ra[3:0]] || (we && wa == ra);
  endfunction

  function automatic int m_count();
    int c = 0;
    foreach (m_busy[i]) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic m_clear();
    foreach (m_reg[i]) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic cmp_all();
    check_eq("rd1", rd1, m_data(rr1, 1));
    check_eq("rd2", rd2, m_data(rr2, 1));
    check_eq("rb1", rb1, m_rbusy(rr1, 1));
    check_eq("rb2", rb2, m_rbusy(rr2, 1));
    check_eq("accept", acc, m_accept());
    check_eq("count", cnt, m_count());
    check_eq("nb_rd1", rd1_nb, m_data(rr1, 0));
    check_eq("nb_rb2", rb2_nb, m_rbusy(rr2, 0));
    check_eq("nb_accept", acc_nb, m_accept());
    check_eq("nb_count", cnt_nb, m_count());
  endtask

  // Called just after a falling edge; applies inputs and compares combinational outputs.
  task automatic drive(input logic w_en, input logic [AW-1:0] w_a, input logic [W-1:0] w_d,
                       input logic r_en, input logic [AW-1:0] r_a,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    we = w_en; wa = w_a; wd = w_d; rsv = r_en; ra = r_a; rr1 = a1; rr2 = a2;
    #1;
    cmp_all();
  endtask

  task automatic tick();
    bit a;
    @(posedge clk);
    a = m_accept();
    if (we && m_writable(wa)) begin
      m_reg[wa[3:0]]  = wd;
      m_busy[wa[3:0]] = 1'b0;
    end
    if (a && m_writable(ra)) m_busy[ra[3:0]] = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    m_clear();
    #1;
    check_eq("reset_rd1", rd1, 0);
    check_eq("reset_count", cnt, 0);
    #11 rst = 1'b0;
    @(negedge clk);

    // Reset asserted between edges wipes data and busy bits at once.
    drive(1, 5, 32'hDEADBEEF, 1, 3, 5, 3);
    tick();
    drive(0, 0, 0, 0, 0, 5, 3);
    check_eq("pre_rst_rd1", rd1, 32'hDEADBEEF);
    check_eq("pre_rst_count", cnt, 1);
    #2 rst = 1'b1;
    #1;
    m_clear();
    check_eq("async_rst_rd1", rd1, 0);
    check_eq("async_rst_rb2", rb2, 0);
    check_eq("async_rst_count", cnt, 0);
    #2 rst = 1'b0;
    @(negedge clk);

    // Bypass versus registered-only read of a landing write.
    drive(1, 5, 32'h12345678, 0, 0, 5, 5);
    check_eq("bypass_rd1", rd1, 32'h12345678);
    check_eq("nobypass_old", rd1_nb, 0);
    tick();
    drive(0, 0, 0, 0, 0, 5, 5);
    check_eq("nobypass_new", rd1_nb, 32'h12345678);

    // Entry 0 ignores writes and reservations.
    drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0, 0, 0);
    check_eq("zero_rd", rd1, 0);
    check_eq("zero_accept", acc, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check_eq("zero_rb", rb1, 0);
    check_eq("zero_count", cnt, 0);

    // Reserve, duplicate reserve, release.
    drive(0, 0, 0, 1, 7, 7, 7);
    check_eq("r7_accept", acc, 1);
    tick();
    drive(0, 0, 0, 1, 7, 7, 7);
    check_eq("r7_busy", rb1, 1);
    check_eq("r7_count", cnt, 1);
    check_eq("r7_dup_reject", acc, 0);
    tick();
    drive(1, 7, 32'hA5, 0, 0, 7, 7);
    tick();
    drive(0, 0, 0, 0, 0, 7, 7);
    check_eq("r7_released", rb1, 0);
    check_eq("r7_data", rd1, 32'hA5);
    check_eq("r7_count0", cnt, 0);

    // Release and re-reserve of the same register in one cycle.
    drive(0, 0, 0, 1, 9, 9, 9);
    tick();
    drive(1, 9, 32'hCAFE, 1, 9, 9, 9);
    check_eq("r9_accept", acc, 1);
    tick();
    drive(0, 0, 0, 0, 0, 9, 9);
    check_eq("r9_data", rd1, 32'hCAFE);
    check_eq("r9_busy", rb1, 1);
    check_eq("r9_count", cnt, 1);

    // Out-of-range addresses.
    drive(0, 0, 0, 1, 20, 20, 20);
    check_eq("oor_rd", rd1, 0);
    check_eq("oor_rb", rb1, 0);
    check_eq("oor_accept", acc, 0);
    tick();
    drive(1, 20, 32'hFFFF, 0, 0, 4, 20);
    tick();

    for (int n = 0; n < 400; n++) begin
      drive(logic'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), W'($urandom),
            logic'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 31)),
            AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
      tick();
    end

    // Final sweep compares every entry's data and busy bit against the model.
    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 0, 0, AW'(a), AW'(a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
